i2c_arbiter: RTL and testbench
==============================

// Module: i2c_arbiter
// PURPOSE
//  Shares one i2c_dri instance between N_REQ independent requesters (e.g. e2prom_rw, RTC, touch config).
//  Round-robin grant per transaction; issues the single-cycle i2c_exec and routes i2c_done/i2c_data_r back to the winner.
//  Adds a per-transaction timeout watchdog and a post-write gap covering the EEPROM internal write cycle.
//  Clocked by dri_clk from i2c_dri. Sits between the user modules and i2c_dri.
// PARAMETERS
//  N_REQ      2          number of requesters, 2..4
//  TIMEOUT    16'd2000   dri_clk cycles allowed from i2c_exec to i2c_done before an error is flagged
//  WR_GAP     16'd5000   idle dri_clk cycles after a completed write (5 ms at 1 MHz); 0 = none
// PORTS
//  clk         in   1          dri_clk from i2c_dri
//  rst_n       in   1          asynchronous reset, active low
//  req         in   N_REQ      per-requester request level; held until own req_done
//  req_rh_wl   in   N_REQ      per-requester read(1)/write(0)
//  req_addr    in   16*N_REQ   per-requester word address; slice i = [16*i+15:16*i]
//  req_data_w  in   8*N_REQ    per-requester write data
//  req_grant   out  N_REQ      one-hot; set while that requester's transaction is in flight
//  req_done    out  N_REQ      one-cycle completion pulse to the granted requester
//  req_err     out  1          valid with req_done; 1 = timeout
//  rd_data     out  8          shared read data; valid with req_done (read, no error)
//  busy        out  1          high in every state except IDLE
//  i2c_exec    out  1          one-cycle start pulse to i2c_dri
//  i2c_rh_wl   out  1          registered command to i2c_dri
//  i2c_addr    out  16         registered command to i2c_dri
//  i2c_data_w  out  8          registered command to i2c_dri
//  i2c_done    in   1          completion pulse from i2c_dri
//  i2c_data_r  in   8          read data from i2c_dri
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; RR pointer so that requester 0 has highest priority; timer 0.
//  FSM: IDLE -> ISSUE -> WAIT -> GAP -> IDLE.
//   IDLE: on edge with |req, pick winner g = first set req searching from (last+1) mod N_REQ.
//         Register req_grant=1<<g and g's rh_wl/addr/data_w into i2c_*; go ISSUE. No req: stay.
//   ISSUE: i2c_exec=1 exactly this cycle; timer cleared; go WAIT. First exec cycle is 1 clk after req seen.
//   WAIT: timer increments.
//         i2c_done=1: next cycle req_done[g]=1, req_err=0, rd_data<=i2c_data_r (reads only; held on writes).
//         timer==TIMEOUT-1 without done: req_done[g]=1, req_err=1, rd_data unchanged.
//         If both occur in the same cycle, done wins (err=0). Either way -> GAP; last<=g; req_grant cleared with req_done.
//   GAP: after a successful write, wait WR_GAP cycles; after a read, a timeout, or WR_GAP==0, leave after 1 cycle. -> IDLE.
//  i2c_done outside WAIT is ignored. Requesters change only their own slice, and only while not granted.
//  Withdrawing req while granted does not abort; req_done still pulses.
//  Back-to-back: a requester still holding req after its done is re-arbitrated fairly; others win first.
//  Asserting rst_n low mid-transaction returns to IDLE immediately with outputs 0; i2c_dri shares rst_n.
//  Counters are 16 bit, saturate-free (bounded by TIMEOUT/WR_GAP). Index g is $clog2(N_REQ) bits.
// STRUCTURE
//  Package i2c_arb_pkg: FSM state encoding (IDLE/ISSUE/WAIT/GAP, 2 bit), CNT_W=16.
//  Sub-module i2c_rr_pick: combinational round-robin select (req, last -> g, any). The FSM, timer and mux live in the top.
// TESTING
//  Single req[0] write addr 16'h0012 data 8'hA5 -> i2c_exec pulse 1 clk after req, i2c_addr=0012, data_w=A5;
//   done -> req_done[0] with err=0; busy holds WR_GAP cycles.
//  req[1] read addr 16'h0034, model returns 8'h5C -> req_done[1], rd_data=5C, err=0; gap 1 cycle.
//  req[0] and req[1] both held, 4 reads -> grants alternate 0,1,0,1; no exec while busy.
//  Model never returns i2c_done -> req_done with req_err=1 exactly TIMEOUT cycles after exec; next request is served.
//  Stray i2c_done in IDLE or GAP -> no req_done, no state change.
//  rst_n low during WAIT -> all outputs 0 at once; after release, req[0] is granted first.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// -----------------------------------------------------------------------------
// i2c_arb_pkg
//   Shared definitions for the I2C requester arbiter.
//   - arb_state_t : arbiter FSM encoding (IDLE/ISSUE/WAIT/GAP, 2 bit)
//   - CNT_W       : width of the timeout / write-gap counter
// -----------------------------------------------------------------------------
package i2c_arb_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// -----------------------------------------------------------------------------
// i2c_rr_pick
//   Combinational round-robin selector. Searches the request vector starting
//   at (i_last + 1) mod N_REQ and returns the first set index.
// Ports
//   i_req   in  N_REQ   request levels
//   i_last  in  IDX_W   index of the most recently served requester
//   o_g     out IDX_W   selected requester (valid when o_any)
//   o_any   out 1       at least one request is pending
// -----------------------------------------------------------------------------
module i2c_rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_g,
  output logic             o_any
);

  // Candidate order: w_cand[0] is the requester right after i_last.
  logic [IDX_W-1:0] w_cand [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign w_cand[gi] = IDX_W'((int'(i_last) + gi + 1) % N_REQ);
    end
  endgenerate

  // Scan from the farthest candidate to the nearest so the nearest set
  // request is the last one written and therefore wins.
  always_comb begin
    o_g   = '0;
    o_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        o_g   = w_cand[k];
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_arbiter
//   Shares one i2c_dri between N_REQ requesters. Round-robin grant per
//   transaction, single-cycle i2c_exec, routing of done/read data back to the
//   winner, per-transaction timeout watchdog and a post-write idle gap that
//   covers the EEPROM internal write cycle.
// Ports
//   clk, rst_n      dri_clk from i2c_dri, asynchronous active-low reset
//   req             per-requester request level (held until own req_done)
//   req_rh_wl       per-requester read(1)/write(0)
//   req_addr        per-requester 16-bit word address, slice i = [16*i+:16]
//   req_data_w      per-requester 8-bit write data, slice i = [8*i+:8]
//   req_grant       one-hot, set while that requester's transaction is in flight
//   req_done        one-cycle completion pulse to the granted requester
//   req_err         1 = the completing transaction timed out
//   rd_data         read data, updated on successful reads only
//   busy            high in every state except IDLE
//   i2c_exec        one-cycle start pulse to i2c_dri
//   i2c_rh_wl/i2c_addr/i2c_data_w  registered command to i2c_dri
//   i2c_done/i2c_data_r            completion and read data from i2c_dri
// -----------------------------------------------------------------------------
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int               N_REQ   = 2,       // 2..4
  parameter logic [CNT_W-1:0] TIMEOUT = 16'd2000,
  parameter logic [CNT_W-1:0] WR_GAP  = 16'd5000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_rh_wl,
  input  logic [16*N_REQ-1:0]  req_addr,
  input  logic [8*N_REQ-1:0]   req_data_w,
  output logic [N_REQ-1:0]     req_grant,
  output logic [N_REQ-1:0]     req_done,
  output logic                 req_err,
  output logic [7:0]           rd_data,
  output logic                 busy,
  output logic                 i2c_exec,
  output logic                 i2c_rh_wl,
  output logic [15:0]          i2c_addr,
  output logic [7:0]           i2c_data_w,
  input  logic                 i2c_done,
  input  logic [7:0]           i2c_data_r
);

  localparam int               IDX_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE   = N_REQ'(1);

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic [IDX_W-1:0] r_g;
  logic [IDX_W-1:0] r_last;
  logic [CNT_W-1:0] r_timer;
  logic             r_gap_long;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_done;
  logic             r_err;
  logic [7:0]       r_rd_data;
  logic             r_exec;
  logic             r_rh_wl;
  logic [15:0]      r_addr;
  logic [7:0]       r_data_w;

  logic [IDX_W-1:0] w_g;
  logic             w_any;
  logic             w_finish;
  logic [15:0]      w_addr   [N_REQ];
  logic [7:0]       w_data_w [N_REQ];

  // Unpack the flat per-requester command buses.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_addr[gi]   = req_addr[16*gi +: 16];
      assign w_data_w[gi] = req_data_w[8*gi +: 8];
    end
  endgenerate

  i2c_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req  (req),
    .i_last (r_last),
    .o_g    (w_g),
    .o_any  (w_any)
  );

  // Next-state logic. The timer is zero during ISSUE and counts up through
  // ISSUE and WAIT, so the timeout completion pulse lands exactly TIMEOUT
  // cycles after the i2c_exec pulse. A done arriving in the timeout cycle
  // still counts as success.
  always_comb begin
    w_state_next = r_state;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (i2c_done || (r_timer >= TIMEOUT - 16'd1)) begin
          w_finish     = 1'b1;
          w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        // Short gap (one cycle) unless a write just succeeded with WR_GAP>0.
        if (!r_gap_long || (r_timer >= WR_GAP - 16'd1)) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_g        <= '0;
      r_last     <= IDX_W'(N_REQ - 1);   // requester 0 searched first
      r_timer    <= '0;
      r_gap_long <= 1'b0;
      r_grant    <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_rd_data  <= '0;
      r_exec     <= 1'b0;
      r_rh_wl    <= 1'b0;
      r_addr     <= '0;
      r_data_w   <= '0;
    end else begin
      r_state <= w_state_next;
      r_exec  <= 1'b0;
      r_done  <= '0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_g      <= w_g;
            r_grant  <= ONE << w_g;
            r_rh_wl  <= req_rh_wl[w_g];
            r_addr   <= w_addr[w_g];
            r_data_w <= w_data_w[w_g];
            r_timer  <= '0;
            r_exec   <= 1'b1;   // exec is high for the whole ISSUE cycle
          end
        end
        ST_ISSUE: begin
          r_timer <= r_timer + 16'd1;
        end
        ST_WAIT: begin
          r_timer <= r_timer + 16'd1;
          if (w_finish) begin
            r_done     <= r_grant;
            r_err      <= !i2c_done;
            if (i2c_done && r_rh_wl) r_rd_data <= i2c_data_r;
            r_last     <= r_g;
            r_grant    <= '0;
            r_timer    <= '0;
            r_gap_long <= i2c_done && !r_rh_wl && (WR_GAP != 16'd0);
          end
        end
        ST_GAP: begin
          r_timer <= r_timer + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign req_grant  = r_grant;
  assign req_done   = r_done;
  assign req_err    = r_err;
  assign rd_data    = r_rd_data;
  assign busy       = (r_state != ST_IDLE);
  assign i2c_exec   = r_exec;
  assign i2c_rh_wl  = r_rh_wl;
  assign i2c_addr   = r_addr;
  assign i2c_data_w = r_data_w;

endmodule

// File: tb/tb_i2c_arbiter.sv
module tb_i2c_arbiter;

  localparam int          N   = 2;
  localparam logic [15:0] TO  = 16'd20;
  localparam logic [15:0] GAP = 16'd10;
  localparam int          LAT = 3;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  req_rh_wl;
  logic [16*N-1:0] req_addr;
  logic [8*N-1:0]  req_data_w;
  logic [N-1:0]  req_grant;
  logic [N-1:0]  req_done;
  logic          req_err;
  logic [7:0]    rd_data;
  logic          busy;
  logic          i2c_exec;
  logic          i2c_rh_wl;
  logic [15:0]   i2c_addr;
  logic [7:0]    i2c_data_w;
  logic          i2c_done;
  logic [7:0]    i2c_data_r;
  logic          model_done;
  logic          stray_done;

  assign i2c_done = model_done | stray_done;

  i2c_arbiter #(.N_REQ(N), .TIMEOUT(TO), .WR_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rh_wl(req_rh_wl),
    .req_addr(req_addr), .req_data_w(req_data_w), .req_grant(req_grant),
    .req_done(req_done), .req_err(req_err), .rd_data(rd_data), .busy(busy),
    .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl), .i2c_addr(i2c_addr),
    .i2c_data_w(i2c_data_w), .i2c_done(i2c_done), .i2c_data_r(i2c_data_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         idx;
    logic       err;
    logic       chk_data;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  // i2c_dri model: answers LAT cycles after exec; read data = addr[7:0]^model_xor.
  bit         model_en  = 1'b1;
  logic [7:0] model_xor = 8'h00;
  int         mcnt      = 0;
  initial begin
    model_done = 1'b0;
    i2c_data_r = 8'h00;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (rst_n !== 1'b1) mcnt = 0;
      else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          model_done = 1'b1;
          i2c_data_r = i2c_addr[7:0] ^ model_xor;
        end
      end else if (i2c_exec === 1'b1 && model_en) mcnt = LAT;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish within 200000 time units");
    $fatal(1, "watchdog");
  end

  // Advances negedge by negedge until a req_done pulse or the budget runs out.
  task automatic run_until_done(input int budget, output bit got,
                                output int exec_c, output int exec_n, output int done_c);
    got = 1'b0; exec_c = -1; exec_n = 0; done_c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (i2c_exec === 1'b1) begin exec_n++; exec_c = cyc; end
      if (|req_done) begin got = 1'b1; done_c = cyc; break; end
    end
  endtask

  // Counts busy cycles starting at the current negedge.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin n++; @(negedge clk); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_rh_wl = '0; req_addr = '0; req_data_w = '0; stray_done = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({req_grant, req_done, req_err, rd_data, busy, i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w} !== '0) begin
      bad++; $display("FAIL reset_outputs: got grant=%b done=%b busy=%b exec=%b addr=%h want all 0",
                      req_grant, req_done, busy, i2c_exec, i2c_addr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || i2c_exec !== 1'b0) begin
      bad++; $display("FAIL reset_idle: got busy=%b exec=%b want 0 0", busy, i2c_exec);
    end
  endtask

  task automatic test_single_write();
    bit got; int ec, en, dc, r0, n; exp_t e;
    req_rh_wl[0] = 1'b0; req_addr[15:0] = 16'h0012; req_data_w[7:0] = 8'hA5; req[0] = 1'b1;
    r0 = cyc;
    exp_q.push_back('{0, 1'b0, 1'b0, 8'h00});
    run_until_done(100, got, ec, en, dc);
    total++;
    if (!got || exp_q.size() == 0) begin
      bad++; $display("FAIL wr_done: got no req_done want req_done within 100 cycles");
    end else begin
      e = exp_q.pop_front();
      if (req_done !== (2'b01 << e.idx) || req_err !== e.err) begin
        bad++; $display("FAIL wr_done: got done=%b err=%b want done=%b err=%b", req_done, req_err, 2'b01 << e.idx, e.err);
      end
      total++;
      if (ec - r0 != 1) begin bad++; $display("FAIL wr_exec_lat: got %0d want 1", ec - r0); end
      total++;
      if (i2c_addr !== 16'h0012 || i2c_data_w !== 8'hA5 || i2c_rh_wl !== 1'b0) begin
        bad++; $display("FAIL wr_cmd: got addr=%h data=%h rh_wl=%b want 0012 a5 0", i2c_addr, i2c_data_w, i2c_rh_wl);
      end
      total++;
      if (req_grant !== 2'b00) begin bad++; $display("FAIL wr_grant_clr: got %b want 00", req_grant); end
    end
    req[0] = 1'b0;
    count_busy(n);
    total++;
    if (n != int'(GAP)) begin bad++; $display("FAIL wr_gap: got %0d want %0d", n, GAP); end
  endtask

  task automatic test_single_read();
    bit got; int ec, en, dc, n; exp_t e;
    model_xor = 8'h34 ^ 8'h5C;   // model returns 5C for address 0034
    req_rh_wl[1] = 1'b1; req_addr[31:16] = 16'h0034; req[1] = 1'b1;
    exp_q.push_back('{1, 1'b0, 1'b1, 8'h5C});
    run_until_done(100, got, ec, en, dc);
    total++;
    if (!got || exp_q.size() == 0) begin
      bad++; $display("FAIL rd_done: got no req_done want req_done within 100 cycles");
    end else begin
      e = exp_q.pop_front();
      if (req_done !== (2'b01 << e.idx) || req_err !== e.err || rd_data !== e.data) begin
        bad++; $display("FAIL rd_done: got done=%b err=%b data=%h want done=%b err=%b data=%h",
                        req_done, req_err, rd_data, 2'b01 << e.idx, e.err, e.data);
      end
      total++;
      if (i2c_addr !== 16'h0034 || i2c_rh_wl !== 1'b1) begin
        bad++; $display("FAIL rd_cmd: got addr=%h rh_wl=%b want 0034 1", i2c_addr, i2c_rh_wl);
      end
    end
    req[1] = 1'b0;
    count_busy(n);
    total++;
    if (n != 1) begin bad++; $display("FAIL rd_gap: got %0d want 1", n); end
  endtask

  task automatic test_back_to_back();
    bit got; int ec, en, dc, n; exp_t e;
    model_xor = 8'h00;
    req_rh_wl = 2'b11; req_addr = {16'h0041, 16'h0040}; req = 2'b11;
    for (int t = 0; t < 4; t++) exp_q.push_back('{t % 2, 1'b0, 1'b1, (t % 2 == 0) ? 8'h40 : 8'h41});
    for (int t = 0; t < 4; t++) begin
      run_until_done(100, got, ec, en, dc);
      total++;
      if (!got || exp_q.size() == 0) begin
        bad++; $display("FAIL b2b_done[%0d]: got no req_done want req_done within 100 cycles", t);
      end else begin
        e = exp_q.pop_front();
        if (req_done !== (2'b01 << e.idx) || req_err !== e.err || rd_data !== e.data) begin
          bad++; $display("FAIL b2b_done[%0d]: got done=%b err=%b data=%h want done=%b err=%b data=%h",
                          t, req_done, req_err, rd_data, 2'b01 << e.idx, e.err, e.data);
        end
        total++;
        if (en != 1) begin bad++; $display("FAIL b2b_exec_count[%0d]: got %0d want 1", t, en); end
      end
      if (t == 3) req = 2'b00;
    end
    count_busy(n);
    exp_q.delete();
  endtask

  task automatic test_timeout();
    bit got; int ec, en, dc, n; exp_t e;
    model_en = 1'b0;
    req_rh_wl[0] = 1'b0; req_addr[15:0] = 16'h0077; req_data_w[7:0] = 8'h11; req[0] = 1'b1;
    exp_q.push_back('{0, 1'b1, 1'b1, 8'h41});   // read data must stay at last read value
    run_until_done(200, got, ec, en, dc);
    total++;
    if (!got || exp_q.size() == 0) begin
      bad++; $display("FAIL to_done: got no req_done want req_done within 200 cycles");
    end else begin
      e = exp_q.pop_front();
      if (req_done !== (2'b01 << e.idx) || req_err !== e.err || rd_data !== e.data) begin
        bad++; $display("FAIL to_done: got done=%b err=%b data=%h want done=%b err=%b data=%h",
                        req_done, req_err, rd_data, 2'b01 << e.idx, e.err, e.data);
      end
      total++;
      if (dc - ec != int'(TO)) begin bad++; $display("FAIL to_latency: got %0d want %0d", dc - ec, TO); end
    end
    req[0] = 1'b0;
    count_busy(n);
    total++;
    if (n != 1) begin bad++; $display("FAIL to_gap: got %0d want 1", n); end
    model_en = 1'b1;
    req_rh_wl[1] = 1'b1; req_addr[31:16] = 16'h0055; req[1] = 1'b1;
    exp_q.push_back('{1, 1'b0, 1'b1, 8'h55});
    run_until_done(100, got, ec, en, dc);
    total++;
    if (!got || exp_q.size() == 0) begin
      bad++; $display("FAIL to_next: got no req_done want req_done within 100 cycles");
    end else begin
      e = exp_q.pop_front();
      if (req_done !== (2'b01 << e.idx) || req_err !== e.err || rd_data !== e.data) begin
        bad++; $display("FAIL to_next: got done=%b err=%b data=%h want done=%b err=%b data=%h",
                        req_done, req_err, rd_data, 2'b01 << e.idx, e.err, e.data);
      end
    end
    req[1] = 1'b0;
    count_busy(n);
  endtask

  task automatic test_stray_done();
    bit got; int ec, en, dc, n, extra; exp_t e;
    extra = 0;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (|req_done || busy !== 1'b0) extra++;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL stray_idle: got %0d active cycles want 0", extra); end
    req_rh_wl[0] = 1'b0; req_addr[15:0] = 16'h0099; req_data_w[7:0] = 8'h22; req[0] = 1'b1;
    exp_q.push_back('{0, 1'b0, 1'b0, 8'h00});
    run_until_done(100, got, ec, en, dc);
    total++;
    if (!got || exp_q.size() == 0) begin
      bad++; $display("FAIL stray_wr_done: got no req_done want req_done within 100 cycles");
    end else begin
      e = exp_q.pop_front();
      if (req_done !== (2'b01 << e.idx) || req_err !== e.err) begin
        bad++; $display("FAIL stray_wr_done: got done=%b err=%b want done=%b err=%b", req_done, req_err, 2'b01 << e.idx, e.err);
      end
    end
    req[0] = 1'b0;
    n = 1; extra = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      stray_done = (i == 1);
      if (|req_done) extra++;
      if (busy !== 1'b1) break;
      n++;
    end
    stray_done = 1'b0;
    total++;
    if (n != int'(GAP) || extra != 0) begin
      bad++; $display("FAIL stray_gap: got gap=%0d dones=%0d want gap=%0d dones=0", n, extra, GAP);
    end
  endtask

  task automatic test_reset_mid();
    bit got; int ec, en, dc, n; exp_t e;
    model_xor = 8'h00;
    req_rh_wl[0] = 1'b1; req_addr[15:0] = 16'h0066; req[0] = 1'b1;
    exp_q.push_back('{0, 1'b0, 1'b1, 8'h66});
    run_until_done(100, got, ec, en, dc);
    total++;
    if (!got || exp_q.size() == 0) begin
      bad++; $display("FAIL rst_pre: got no req_done want req_done within 100 cycles");
    end else begin
      e = exp_q.pop_front();
      if (req_done !== (2'b01 << e.idx) || rd_data !== e.data) begin
        bad++; $display("FAIL rst_pre: got done=%b data=%h want done=%b data=%h", req_done, rd_data, 2'b01 << e.idx, e.data);
      end
    end
    req[0] = 1'b0;
    count_busy(n);
    model_en = 1'b0;
    req_rh_wl[1] = 1'b1; req_addr[31:16] = 16'h0033; req[1] = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b1 || req_grant !== 2'b10) begin
      bad++; $display("FAIL rst_wait: got busy=%b grant=%b want 1 10", busy, req_grant);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_grant, req_done, req_err, rd_data, busy, i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w} !== '0) begin
      bad++; $display("FAIL rst_async: got grant=%b busy=%b rd=%h addr=%h want all 0", req_grant, busy, rd_data, i2c_addr);
    end
    @(negedge clk);
    rst_n = 1'b1; model_en = 1'b1;
    req[0] = 1'b1;
    exp_q.push_back('{0, 1'b0, 1'b1, 8'h66});
    exp_q.push_back('{1, 1'b0, 1'b1, 8'h33});
    for (int t = 0; t < 2; t++) begin
      run_until_done(100, got, ec, en, dc);
      total++;
      if (!got || exp_q.size() == 0) begin
        bad++; $display("FAIL rst_after[%0d]: got no req_done want req_done within 100 cycles", t);
      end else begin
        e = exp_q.pop_front();
        if (req_done !== (2'b01 << e.idx) || rd_data !== e.data) begin
          bad++; $display("FAIL rst_after[%0d]: got done=%b data=%h want done=%b data=%h",
                          t, req_done, rd_data, 2'b01 << e.idx, e.data);
        end
      end
      if (t == 1) req = 2'b00;
    end
    count_busy(n);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_timeout();
    test_stray_done();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
